qam16_upmapper: RTL
===================

Name: qam16_upmapper

Overview:
- Upstream neighbour of the RRC pulse-shaping FIR.
- Consumes the serial PRBS-23 bit stream and packs 4 bits into one 16-QAM symbol.
- Gray-maps each symbol to Q1.11 I/Q levels and upsamples by SPS (zero-stuffing) into a valid/ready sample stream at the FIR input.

Parameters:
- SPS, 4, samples per symbol; ≥2.
- DATA_WIDTH, 12, I/Q sample width (Q1.11 signed).
- BITS_PER_SYM, 4, bits per symbol; fixed at 4, elaboration error otherwise.

Ports:
- clk  in  1  system clock (27 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- sync_clr  in  1  synchronous flush, active-high
- bit_data  in  1  serial bit from LFSR
- bit_valid  in  1  bit_data valid
- bit_ready  out  1  block accepts bit this cycle
- out_i  out  DATA_WIDTH  signed I sample
- out_q  out  DATA_WIDTH  signed Q sample
- out_valid  out  1  sample valid
- out_ready  in  1  downstream (FIR) accepts sample
- sym_strobe  out  1  high with the phase-0 sample of each symbol (qualified by out_valid)

Behaviour:
- Reset (rst_n=0, async) and sync_clr (sync):
  - bit_cnt=0, shift=0, phase=0, emitter idle.
  - out_valid=0, out_i=out_q=0, sym_strobe=0.
  - sync_clr has priority over all other activity in its cycle.
- Bit packing:
  - A bit is accepted when bit_valid && bit_ready.
  - The first accepted bit is b3 (MSB), the last is b0.
  - bit_cnt counts 0..4.
  - bit_ready = (bit_cnt<4) || symbol_load, where symbol_load means the nibble moves to the emitter this cycle. Throughput is one bit per clock with no bubbles.
- Gray map: I from {b3,b2}, Q from {b1,b0}.
  - 00 → -1943 (12'h869)
  - 01 → -648 (12'hD78)
  - 11 → +648 (12'h288)
  - 10 → +1943 (12'h797)
- Emitter: two states, IDLE and EMIT.
  - IDLE → EMIT when bit_cnt==4.
    - Registers the mapped symbol into the output; out_valid=1, sym_strobe=1, phase=0.
    - Clears bit_cnt; if a bit is accepted in the same cycle, bit_cnt=1.
  - EMIT, on each out_valid && out_ready handshake: phase increments.
    - Phases 1..SPS-1 present out_i=out_q=0, with sym_strobe=0.
  - At the handshake of phase SPS-1:
    - If bit_cnt==4: the next symbol loads at phase 0 in the same edge, so a continuous stream has no gap.
    - Otherwise: go to IDLE with out_valid=0.
- Latency: out_valid rises on the clock edge that follows the edge capturing the 4th bit, when the emitter is IDLE.
- Backpressure:
  - While out_valid && !out_ready, out_i, out_q, sym_strobe and phase hold stable.
  - Bit intake continues until bit_cnt==4, then bit_ready=0.
- No combinational path from out_ready to out_valid or data. bit_ready may depend combinationally on out_ready through symbol_load.
- Arithmetic: none beyond the LUT. Outputs are exact package constants, no saturation needed.
- bit_valid deasserted mid-nibble: partial nibble retained indefinitely.

Optional Feature:
- Macro: QAM_UPMAPPER_ZOH_EN.
- Defined: phases 1..SPS-1 repeat the symbol's I/Q value (zero-order hold) instead of zero.
- Undefined: zero-stuffing as above.
- sym_strobe, timing and handshakes are identical in both builds.

Test Plan:
- Reset release, out_ready=1, bits 0,0,0,0 → out_valid one cycle after 4th bit. Samples: (-1943,-1943) with sym_strobe=1, then (0,0) x3. Then out_valid=0.
- Bits 1,0,0,1 → first sample I=+1943, Q=-648; bits 1,1,1,0 → I=+648, Q=+1943. All 16 nibbles checked against the Gray table.
- Continuous bit_valid=1 with out_ready=1 for 64 bits → 64 contiguous valid samples. bit_ready never low; sym_strobe every 4th sample.
- out_ready=0 for 10 cycles mid-symbol → outputs frozen. bit_ready drops after 4 buffered bits. Resume yields no lost or duplicated sample or bit.
- rst_n asserted asynchronously mid-EMIT with 2 bits buffered → outputs 0 immediately. After release, the next 4 bits form a fresh symbol with no stale bits.
- Build with QAM_UPMAPPER_ZOH_EN, bits 0,1,1,1 → four samples of (-648,+648), sym_strobe only on the first.

Source files
------------

// File: rtl/qam16_upmapper.sv
// -----------------------------------------------------------------------------
// qam16_upmapper
//
// Packs a serial bit stream into 16-QAM symbols, Gray-maps each symbol to
// Q1.11 I/Q levels and upsamples by SPS into a valid/ready sample stream
// feeding the RRC pulse-shaping FIR.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sync_clr   in   synchronous flush, active-high, overrides everything
//   bit_data   in   serial data bit (first bit of a nibble is b3)
//   bit_valid  in   bit_data valid
//   bit_ready  out  bit accepted this cycle when bit_valid is also high
//   out_i      out  signed I sample, DATA_WIDTH bits
//   out_q      out  signed Q sample, DATA_WIDTH bits
//   out_valid  out  sample valid
//   out_ready  in   downstream accepts the sample
//   sym_strobe out  marks the phase-0 sample of each symbol
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// A source never withdraws valid or changes its data while waiting for
// ready. out_valid/out_i/out_q/sym_strobe are registered; bit_ready looks at
// out_ready combinationally so a new nibble can be taken in the same cycle
// the previous one moves into the emitter.
//
// Build option:
//   QAM_UPMAPPER_ZOH_EN  defined   -> phases 1..SPS-1 repeat the symbol level
//                        undefined -> phases 1..SPS-1 are zero (zero-stuffing)
// -----------------------------------------------------------------------------
module qam16_upmapper #(
  parameter int SPS          = 4,
  parameter int DATA_WIDTH   = 12,
  parameter int BITS_PER_SYM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sync_clr,
  input  logic                  bit_data,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [DATA_WIDTH-1:0] out_i,
  output logic [DATA_WIDTH-1:0] out_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sym_strobe
);

  generate
    if (BITS_PER_SYM != 4) begin : g_bps_check
      $error("qam16_upmapper: BITS_PER_SYM must be 4");
    end
    if (SPS < 2) begin : g_sps_check
      $error("qam16_upmapper: SPS must be at least 2");
    end
  endgenerate

  localparam int                 PH_W    = $clog2(SPS);
  localparam logic [PH_W-1:0]    PH_LAST = PH_W'(SPS - 1);

  // Q1.11 Gray levels
  localparam logic [DATA_WIDTH-1:0] LVL_N3 = DATA_WIDTH'(-1943);
  localparam logic [DATA_WIDTH-1:0] LVL_N1 = DATA_WIDTH'(-648);
  localparam logic [DATA_WIDTH-1:0] LVL_P1 = DATA_WIDTH'(648);
  localparam logic [DATA_WIDTH-1:0] LVL_P3 = DATA_WIDTH'(1943);

  function automatic logic [DATA_WIDTH-1:0] gray_lvl(input logic [1:0] g);
    case (g)
      2'b00:   gray_lvl = LVL_N3;
      2'b01:   gray_lvl = LVL_N1;
      2'b11:   gray_lvl = LVL_P1;
      default: gray_lvl = LVL_P3;
    endcase
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [3:0]            shift_q, shift_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [DATA_WIDTH-1:0] out_i_q, out_i_d;
  logic [DATA_WIDTH-1:0] out_q_q, out_q_d;
  logic                  strobe_q, strobe_d;

  logic handshake;
  logic last_hs;
  logic sym_full;
  logic symbol_load;
  logic bit_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 4'd0;
      phase_q   <= '0;
      out_i_q   <= '0;
      out_q_q   <= '0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      phase_q   <= phase_d;
      out_i_q   <= out_i_d;
      out_q_q   <= out_q_d;
      strobe_q  <= strobe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    phase_d   = phase_q;
    out_i_d   = out_i_q;
    out_q_d   = out_q_q;
    strobe_d  = strobe_q;

    handshake   = (state_q == ST_EMIT) && out_ready;
    last_hs     = handshake && (phase_q == PH_LAST);
    sym_full    = (bit_cnt_q == 3'd4);
    // The buffered nibble moves to the emitter when the emitter is idle or
    // is finishing its last phase right now.
    symbol_load = sym_full && ((state_q == ST_IDLE) || last_hs);
    bit_ready   = !sym_full || symbol_load;
    bit_acc     = bit_valid && bit_ready;

    // Bit intake: shifting left leaves the first bit in b3.
    if (symbol_load) begin
      bit_cnt_d = bit_acc ? 3'd1 : 3'd0;
      shift_d   = bit_acc ? {3'b000, bit_data} : 4'b0000;
    end else if (bit_acc) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shift_d   = {shift_q[2:0], bit_data};
    end

    // Emitter
    if (symbol_load) begin
      state_d  = ST_EMIT;
      phase_d  = '0;
      out_i_d  = gray_lvl(shift_q[3:2]);
      out_q_d  = gray_lvl(shift_q[1:0]);
      strobe_d = 1'b1;
    end else if (last_hs) begin
      state_d  = ST_IDLE;
      phase_d  = '0;
      out_i_d  = '0;
      out_q_d  = '0;
      strobe_d = 1'b0;
    end else if (handshake) begin
      phase_d  = phase_q + 1'b1;
      strobe_d = 1'b0;
`ifdef QAM_UPMAPPER_ZOH_EN
      // Zero-order hold: the phase-0 level stays on the outputs.
      out_i_d  = out_i_q;
      out_q_d  = out_q_q;
`else
      out_i_d  = '0;
      out_q_d  = '0;
`endif
    end

    if (sync_clr) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      shift_d   = 4'd0;
      phase_d   = '0;
      out_i_d   = '0;
      out_q_d   = '0;
      strobe_d  = 1'b0;
    end
  end

  assign out_valid  = (state_q == ST_EMIT);
  assign out_i      = out_i_q;
  assign out_q      = out_q_q;
  assign sym_strobe = strobe_q;

endmodule
